// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the round-robin data-memory arbiter.
// The optional per-core grant counters are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int STAT_W      = 16;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// The wrap is handled by scanning a doubled copy of the request vector.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   sel_o,
    output logic               valid_o
);

    localparam int             DW   = 2 * NUM_REQ;
    localparam logic [PTR_W:0] NREQ = (PTR_W + 1)'(NUM_REQ);

    logic [DW-1:0] doubled;
    logic [PTR_W:0] hit;

    assign doubled = {req_i, req_i};

    // Lowest set index at or above ptr wins; indices in the upper copy fold back by NUM_REQ.
    always_comb begin
        hit = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (doubled[i] && (i >= int'(ptr_i))) begin
                hit = (PTR_W + 1)'(i);
            end
        end
        if (hit >= NREQ) begin
            hit = hit - NREQ;
        end
        sel_o = hit[PTR_W-1:0];
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NUM_REQ core MEM stages.
// Define MEM_ARB_STATS_EN to add saturating per-core grant counters on stat_cnt.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]   stat_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [PTR_W-1:0]  pickSel;
    logic              pickValid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .sel_o   (pickSel),
        .valid_o (pickValid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM read data arrives in RESP, so rdata bypasses the holding register during the ack cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rdata   = rdata_q;
        ack     = '0;
        mem_en  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pickValid) begin
                    sel_d   = pickSel;
                    we_d    = req_we[pickSel];
                    addr_d  = req_addr[pickSel*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[pickSel*DATA_W +: DATA_W];
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                mem_en  = 1'b1;
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                ack[sel_q] = 1'b1;
                if (!we_q) begin
                    rdata_d = mem_rdata;
                    rdata   = mem_rdata;
                end
                ptr_d   = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + PTR_W'(1);
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ARB_IDLE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if ((state_q == ARB_RESP) && (stat_q[sel_q] != '1)) begin
            stat_q[sel_q] <= stat_q[sel_q] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected acks are queued at stimulus time and
// popped as the DUT acks; a small registered RAM model sits on the memory port.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   ack;
    logic [31:0]  rdata;
    logic         busy;
    logic         mem_en;
    logic         mem_we;
    logic [7:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [63:0]  statCnt;
`endif

    typedef struct {
        int          core;
        int          cycle;
        bit          load;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ram [256];
    int          cycleNow = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    bit          holdReq = 1'b0;

    mem_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (8),
        .DATA_W  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_cnt  (statCnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNow <= cycleNow + 1;

    // Single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic doReset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setReq(input int core, input bit we, input logic [7:0] addr, input logic [31:0] wdata);
        req_we[core]              = we;
        req_addr[core*8 +: 8]     = addr;
        req_wdata[core*32 +: 32]  = wdata;
        req[core]                 = 1'b1;
    endtask

    task automatic pushExp(input int core, input int cyc, input bit load, input logic [31:0] data);
        exp_t e;
        e.core  = core;
        e.cycle = cyc;
        e.load  = load;
        e.data  = data;
        sbq.push_back(e);
    endtask

    // Waits (bounded) for the next ack; rel is cycles since base, -1 on timeout.
    task automatic waitAck(input int base, output int rel, output logic [3:0] a, output logic [31:0] d);
        rel = -1;
        a   = '0;
        d   = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                rel = cycleNow - base;
                a   = ack;
                d   = rdata;
                if (!holdReq) req = req & ~ack;
                return;
            end
        end
    endtask

    task automatic test_reset();
        doReset();
        rst = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({ack, busy, mem_en, mem_we} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset ctrl: got ack=%b busy=%b en=%b we=%b, expected all 0", ack, busy, mem_en, mem_we);
        end
        testsRun++;
        if (mem_addr !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset mem_addr: got %h expected 00", mem_addr);
        end
        testsRun++;
        if (mem_wdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset mem_wdata: got %h expected 0", mem_wdata);
        end
        testsRun++;
        if (rdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset rdata: got %h expected 0", rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int base, rel;
        logic [3:0] a;
        logic [31:0] d;
        exp_t e;
        for (int t = 0; t < 2; t++) begin
            base = cycleNow;
            if (t == 0) begin
                setReq(1, 1'b1, 8'h10, 32'hDEADBEEF);
                pushExp(1, 2, 1'b0, 32'h0);
            end else begin
                setReq(1, 1'b0, 8'h10, 32'h0);
                pushExp(1, 2, 1'b1, 32'hDEADBEEF);
            end
            @(negedge clk);
            testsRun++;
            if ({mem_en, mem_we, mem_addr} !== {1'b1, (t == 0), 8'h10}) begin
                testsFailed++;
                $display("[TB] FAIL store_load grant%0d: got en=%b we=%b addr=%h expected en=1 we=%0d addr=10", t, mem_en, mem_we, mem_addr, (t == 0));
            end
            if (t == 0) begin
                testsRun++;
                if (mem_wdata !== 32'hDEADBEEF) begin
                    testsFailed++;
                    $display("[TB] FAIL store_load wdata: got %h expected deadbeef", mem_wdata);
                end
            end
            waitAck(base, rel, a, d);
            e = sbq.pop_front();
            testsRun++;
            if (a !== (4'b0001 << e.core) || rel !== e.cycle) begin
                testsFailed++;
                $display("[TB] FAIL store_load ack%0d: got ack=%b at %0d expected ack=%b at %0d", t, a, rel, 4'b0001 << e.core, e.cycle);
            end
            if (e.load) begin
                testsRun++;
                if (d !== e.data) begin
                    testsFailed++;
                    $display("[TB] FAIL store_load rdata: got %h expected %h", d, e.data);
                end
            end
            @(negedge clk);
        end
        testsRun++;
        if (rdata !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL store_load rdata held: got %h expected deadbeef", rdata);
        end
    endtask

    task automatic test_fairness();
        int base, rel;
        logic [3:0] a;
        logic [31:0] d;
        exp_t e;
        doReset();
        holdReq = 1'b1;
        base = cycleNow;
        for (int c = 0; c < 4; c++) setReq(c, 1'b0, 8'h10, 32'h0);
        pushExp(0, 2, 1'b1, 32'hDEADBEEF);
        pushExp(1, 5, 1'b1, 32'hDEADBEEF);
        pushExp(2, 8, 1'b1, 32'hDEADBEEF);
        pushExp(3, 11, 1'b1, 32'hDEADBEEF);
        pushExp(0, 14, 1'b1, 32'hDEADBEEF);
        for (int n = 0; n < 5; n++) begin
            waitAck(base, rel, a, d);
            e = sbq.pop_front();
            testsRun++;
            if (a !== (4'b0001 << e.core) || rel !== e.cycle) begin
                testsFailed++;
                $display("[TB] FAIL fairness grant%0d: got ack=%b at %0d expected ack=%b at %0d", n, a, rel, 4'b0001 << e.core, e.cycle);
            end
            testsRun++;
            if (d !== e.data) begin
                testsFailed++;
                $display("[TB] FAIL fairness rdata%0d: got %h expected %h", n, d, e.data);
            end
        end
        req = '0;
        holdReq = 1'b0;
        @(negedge clk);
    endtask

    // ptr is 1 here; a lone core-2 grant moves it to 3 so 4'b0101 must wrap to core 0.
    task automatic test_wrap();
        int base, rel;
        logic [3:0] a;
        logic [31:0] d;
        exp_t e;
        for (int phase = 0; phase < 3; phase++) begin
            base = cycleNow;
            case (phase)
                0: begin
                    setReq(2, 1'b0, 8'h10, 32'h0);
                    pushExp(2, 2, 1'b0, 32'h0);
                end
                1: begin
                    setReq(0, 1'b0, 8'h10, 32'h0);
                    setReq(2, 1'b0, 8'h10, 32'h0);
                    pushExp(0, 2, 1'b0, 32'h0);
                    pushExp(2, 5, 1'b0, 32'h0);
                end
                default: begin
                    for (int c = 0; c < 4; c++) setReq(c, 1'b0, 8'h10, 32'h0);
                    pushExp(3, 2, 1'b0, 32'h0);
                end
            endcase
            while (sbq.size() > 0) begin
                waitAck(base, rel, a, d);
                e = sbq.pop_front();
                testsRun++;
                if (a !== (4'b0001 << e.core) || rel !== e.cycle) begin
                    testsFailed++;
                    $display("[TB] FAIL wrap phase%0d: got ack=%b at %0d expected ack=%b at %0d", phase, a, rel, 4'b0001 << e.core, e.cycle);
                end
            end
            req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_pulse_abort();
        int base, rel, stray;
        logic [3:0] a;
        logic [31:0] d;
        exp_t e;
        base = cycleNow;
        setReq(2, 1'b0, 8'h10, 32'h0);
        pushExp(2, 2, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        req[2] = 1'b0;
        waitAck(base, rel, a, d);
        e = sbq.pop_front();
        testsRun++;
        if (a !== (4'b0001 << e.core) || rel !== e.cycle || d !== e.data) begin
            testsFailed++;
            $display("[TB] FAIL pulse ack: got ack=%b at %0d data=%h expected ack=%b at %0d data=%h", a, rel, d, 4'b0001 << e.core, e.cycle, e.data);
        end
        @(negedge clk);
        setReq(3, 1'b1, 8'h20, 32'h12345678);
        @(negedge clk);
        testsRun++;
        if ({busy, mem_en, mem_we} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL abort grant: got busy=%b en=%b we=%b expected 111", busy, mem_en, mem_we);
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        testsRun++;
        if ({ack, busy} !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort reset: got ack=%b busy=%b expected 0", ack, busy);
        end
        rst = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack !== 4'b0000) stray++;
        end
        testsRun++;
        if (stray !== 0) begin
            testsFailed++;
            $display("[TB] FAIL abort no_ack: got %0d ack cycles expected 0", stray);
        end
        base = cycleNow;
        setReq(0, 1'b0, 8'h20, 32'h0);
        pushExp(0, 2, 1'b1, 32'h12345678);
        waitAck(base, rel, a, d);
        e = sbq.pop_front();
        testsRun++;
        if (a !== (4'b0001 << e.core) || rel !== e.cycle || d !== e.data) begin
            testsFailed++;
            $display("[TB] FAIL abort write_kept: got ack=%b at %0d data=%h expected ack=%b at %0d data=%h", a, rel, d, 4'b0001 << e.core, e.cycle, e.data);
        end
        @(negedge clk);
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        int base, rel;
        logic [3:0] a;
        logic [31:0] d;
        int grants[4] = '{0, 0, 0, 3};
        doReset();
        for (int g = 0; g < 4; g++) begin
            base = cycleNow;
            setReq(grants[g], 1'b0, 8'h10, 32'h0);
            waitAck(base, rel, a, d);
            @(negedge clk);
        end
        testsRun++;
        if (statCnt !== {16'd1, 16'd0, 16'd0, 16'd3}) begin
            testsFailed++;
            $display("[TB] FAIL stats count: got %h expected 0001000000000003", statCnt);
        end
    endtask
`endif

    initial begin
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_store_load();
        test_fairness();
        test_wrap();
        test_pulse_abort();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
